// File: rtl/vmag_apb_pkg.sv
// Shared types and defaults for the vmag APB master.
package vmag_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/vmag_apb_master.sv
// Single-outstanding command-to-APB bridge: a command is turned into one
// SETUP + ACCESS transfer, and the outcome is held as a response until it is
// taken. Slaves that never raise pready are cut off after TIMEOUT_CYCLES.
module vmag_apb_master
  import vmag_apb_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic                      cmd_write_i,
  input  logic [31:0]               cmd_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_slverr_o,
  output logic                      rsp_timeout_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [31:0]               pwdata_o,
  input  logic [31:0]               prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i,
  output logic [15:0]               err_count_o
);

  // Index of the last permitted wait cycle; the counter starts at 0.
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

  state_t                    state_q, state_d;
  logic                      cmd_ready_q;
  logic [7:0]                wait_cnt_q;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [31:0]               pwdata_q;
  logic                      pwrite_q;
  logic [31:0]               rsp_rdata_q;
  logic                      rsp_slverr_q;
  logic                      rsp_timeout_q;
  logic [15:0]               err_count_q;

  logic cmd_fire;
  logic access_done;
  logic access_timeout;

  assign cmd_fire       = cmd_valid_i && cmd_ready_q;
  // pready wins over the limit, so a slave answering on the last allowed
  // cycle completes normally.
  assign access_done    = (state_q == ST_ACCESS) && pready_i;
  assign access_timeout = (state_q == ST_ACCESS) && !pready_i &&
                          (wait_cnt_q == WAIT_LIMIT);

  // Next-state and APB/response strobes decoded from the current state.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        psel_o  = 1'b1;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        if (access_done || access_timeout) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register plus a registered ready so it stays low during reset and
  // rises on the first edge afterwards.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == ST_IDLE);
    end
  end

  // Capture the command payload; it drives the APB bus until the next command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
    end else if (cmd_fire) begin
      paddr_q  <= cmd_addr_i;
      pwdata_q <= cmd_wdata_i;
      pwrite_q <= cmd_write_i;
    end
  end

  // Count ACCESS cycles spent waiting on pready; cleared during SETUP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else if (state_q == ST_SETUP) begin
      wait_cnt_q <= '0;
    end else if ((state_q == ST_ACCESS) && !pready_i) begin
      wait_cnt_q <= wait_cnt_q + 8'd1;
    end
  end

  // Latch the response payload on entry to RESP; held stable until reused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else if (access_done) begin
      rsp_rdata_q   <= pwrite_q ? 32'd0 : prdata_i;
      rsp_slverr_q  <= pslverr_i;
      rsp_timeout_q <= 1'b0;
    end else if (access_timeout) begin
      rsp_rdata_q   <= 32'd0;
      rsp_slverr_q  <= 1'b1;
      rsp_timeout_q <= 1'b1;
    end
  end

  // Saturating count of responses that carry an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_q <= '0;
    end else if (((access_done && pslverr_i) || access_timeout) &&
                 (err_count_q != 16'hFFFF)) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign paddr_o       = paddr_q;
  assign pwdata_o      = pwdata_q;
  assign pwrite_o      = pwrite_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_slverr_o  = rsp_slverr_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign err_count_o   = err_count_q;

endmodule

// File: tb/tb_vmag_apb_master.sv
// Scoreboard bench for vmag_apb_master: a driver issues commands and pushes
// the expected outcome, a behavioural slave answers them, and a monitor
// compares every response cycle against the queued expectation.
module tb_vmag_apb_master;

  localparam int AW = 12;
  localparam int TO = 16;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          cmd_write;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_slverr;
  logic          rsp_timeout;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata;
  logic [31:0]   prdata;
  logic          pready;
  logic          pslverr;
  logic [15:0]   err_count;

  vmag_apb_master #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_addr_i   (cmd_addr),
    .cmd_write_i  (cmd_write),
    .cmd_wdata_i  (cmd_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_slverr_o (rsp_slverr),
    .rsp_timeout_o(rsp_timeout),
    .psel_o       (psel),
    .penable_o    (penable),
    .pwrite_o     (pwrite),
    .paddr_o      (paddr),
    .pwdata_o     (pwdata),
    .prdata_i     (prdata),
    .pready_i     (pready),
    .pslverr_i    (pslverr),
    .err_count_o  (err_count)
  );

  // What the slave should see and how it answers one command.
  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [31:0]   wdata;
    int            waits;   // ACCESS cycles with pready low before answering
    logic          slverr;
    logic [31:0]   rdata;
  } slv_cfg_t;

  // Expected response of one command.
  typedef struct {
    logic [31:0] rdata;
    logic        slverr;
    logic        timeout;
    logic [15:0] err;
    int          lat;      // edge at which rsp_valid is first sampled high
    int          acc;      // number of ACCESS cycles
    int          stall;    // cycles the monitor withholds rsp_ready
  } exp_t;

  slv_cfg_t    cfg_q[$];
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          last_accept = 0;
  logic [15:0] err_model = 16'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Reference model: outcome follows from the slave's wait count alone.
  task automatic issue(input logic [AW-1:0] addr, input logic write, input logic [31:0] wdata,
                       input int waits, input logic slverr, input logic [31:0] rdata,
                       input int stall, input bit expect_rsp);
    slv_cfg_t c;
    exp_t     e;
    bit       accepted = 0;
    bit       timeout = (waits >= TO);
    c.addr = addr; c.write = write; c.wdata = wdata;
    c.waits = waits; c.slverr = slverr; c.rdata = rdata;
    cfg_q.push_back(c);
    e.timeout = timeout;
    e.slverr  = timeout || slverr;
    e.rdata   = (timeout || write) ? 32'd0 : rdata;
    e.acc     = timeout ? TO : waits + 1;
    e.stall   = stall;
    cmd_addr = addr; cmd_write = write; cmd_wdata = wdata; cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        #1;
        accepted = 1;
      end
    end
    cmd_valid = 1'b0;
    if (!accepted) begin
      fail("cmd_accept", "command not accepted within 200 cycles");
    end else begin
      last_accept = cyc;
      if (expect_rsp) begin
        if (e.slverr && err_model != 16'hFFFF) err_model = err_model + 16'd1;
        e.err = err_model;
        e.lat = cyc + 2 + e.acc;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) fail("drain", "responses still outstanding after 2000 cycles");
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Behavioural APB slave plus bus-protocol checks, evaluated after each edge.
  initial begin : slave
    slv_cfg_t cur;
    logic     prev_psel = 1'b0;
    cur = '{addr: '0, write: 1'b0, wdata: '0, waits: 0, slverr: 1'b0, rdata: '0};
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        pready = 1'b0; pslverr = 1'b0; prev_psel = 1'b0;
        continue;
      end
      if (psel && !penable) begin
        if (cfg_q.size() == 0) begin
          fail("setup_cmd", "SETUP seen with no command issued");
        end else begin
          cur = cfg_q.pop_front();
        end
        acc_cnt = 0;
        pready  = 1'b0;
        check("setup_first", 32'(prev_psel), 32'd0);
        check("setup_paddr", 32'(paddr), 32'(cur.addr));
        check("setup_pwrite", 32'(pwrite), 32'(cur.write));
        check("setup_pwdata", pwdata, cur.wdata);
      end else if (psel && penable) begin
        check("access_paddr", 32'(paddr), 32'(cur.addr));
        check("access_pwrite", 32'(pwrite), 32'(cur.write));
        check("access_pwdata", pwdata, cur.wdata);
        pready  = (acc_cnt == cur.waits);
        prdata  = pready ? cur.rdata : $urandom;
        pslverr = pready ? cur.slverr : 1'($urandom);
        acc_cnt++;
      end else begin
        pready = 1'b0; pslverr = 1'b0;
      end
      prev_psel = psel;
    end
  end

  // Monitor: compare every RESP cycle with the head of the scoreboard.
  initial begin : monitor
    exp_t e;
    int   stall_left = 0;
    bit   in_rsp = 0;
    bit   idle_chk = 0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_rsp = 0; idle_chk = 0; rsp_ready = 1'b0;
        continue;
      end
      if (idle_chk) begin
        check("idle_after_rsp", 32'(cmd_ready), 32'd1);
        idle_chk = 0;
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          fail("rsp_unexpected", "rsp_valid high with no response expected");
          rsp_ready = 1'b1;
        end else begin
          e = exp_q[0];
          if (!in_rsp) begin
            in_rsp = 1;
            stall_left = e.stall;
            check("rsp_latency", 32'(cyc + 1), 32'(e.lat));
            check("access_cycles", 32'(acc_cnt), 32'(e.acc));
          end
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_slverr", 32'(rsp_slverr), 32'(e.slverr));
          check("rsp_timeout", 32'(rsp_timeout), 32'(e.timeout));
          check("err_count", 32'(err_count), 32'(e.err));
          check("rsp_psel", 32'({psel, penable}), 32'd0);
          check("rsp_cmd_ready", 32'(cmd_ready), 32'd0);
          if (stall_left == 0) begin
            rsp_ready = 1'b1;
            e = exp_q.pop_front();
            in_rsp = 0;
            idle_chk = 1;
          end else begin
            rsp_ready = 1'b0;
            stall_left--;
          end
        end
      end else begin
        rsp_ready = 1'($urandom);
      end
    end
  end

  initial begin : stimulus
    int t0;
    int w;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0;
    #2;
    check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset_psel", 32'({psel, penable, pwrite}), 32'd0);
    check("reset_rsp", 32'({rsp_valid, rsp_slverr, rsp_timeout}), 32'd0);
    check("reset_paddr", 32'(paddr), 32'd0);
    check("reset_pwdata", pwdata, 32'd0);
    check("reset_rdata", rsp_rdata, 32'd0);
    check("reset_err_count", 32'(err_count), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Zero-wait write, 3-wait read, stuck slave, error write, backpressure.
    issue(12'h000, 1'b1, 32'h2, 0, 1'b0, $urandom, 0, 1);
    issue(12'h008, 1'b0, $urandom, 3, 1'b0, 32'h2, 0, 1);
    issue(12'h010, 1'b0, $urandom, 1000, 1'b0, $urandom, 0, 1);
    issue(12'hFFC, 1'b1, 32'hDEAD_BEEF, 1, 1'b1, $urandom, 0, 1);
    issue(12'h020, 1'b0, $urandom, 2, 1'b0, 32'hCAFE_F00D, 5, 1);
    // pready on the last allowed cycle completes; one later times out.
    issue(12'h030, 1'b0, $urandom, TO - 1, 1'b0, 32'h1234_5678, 0, 1);
    issue(12'h034, 1'b0, $urandom, TO, 1'b0, 32'h1234_5678, 0, 1);
    drain();

    // Back-to-back zero-wait commands: 4-cycle throughput.
    issue(12'h040, 1'b1, 32'h11, 0, 1'b0, 32'h0, 0, 1);
    t0 = last_accept;
    issue(12'h044, 1'b0, 32'h0, 0, 1'b0, 32'h5555_AAAA, 0, 1);
    check("throughput", 32'(last_accept - t0), 32'd4);
    drain();

    // Reset while in ACCESS: the transfer is dropped without a response.
    issue(12'h050, 1'b0, 32'h0, 1000, 1'b0, 32'h0, 0, 0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_psel", 32'({psel, penable}), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("midrst_err_count", 32'(err_count), 32'd0);
    check("midrst_paddr", 32'(paddr), 32'd0);
    err_model = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("postrst_cmd_ready_low", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    check("postrst_cmd_ready_high", 32'(cmd_ready), 32'd1);
    issue(12'h060, 1'b0, 32'h0, 1, 1'b0, 32'h0BAD_CAFE, 0, 1);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      case ($urandom % 8)
        0, 7:    w = 0;
        1, 2, 3: w = int'($urandom % 4);
        4:       w = TO - 1;
        5:       w = TO + int'($urandom % 4);
        default: w = int'($urandom % TO);
      endcase
      issue(AW'($urandom), 1'($urandom), $urandom, w, 1'($urandom % 4 == 0),
            $urandom, int'($urandom % 3), 1);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation still running at 400000, required finish earlier");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vmag_apb_master.md
VMAG_APB_MASTER -- requirements
Module: vmag_apb_master

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12, APB address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum ACCESS cycles without pready_i (range 2..255).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports cmd_valid_i in 1 / cmd_ready_o out 1, the command handshake.
REQ-006 SHALL have ports cmd_addr_i in APB_ADDR_WIDTH / cmd_write_i in 1 / cmd_wdata_i in 32, the command payload.
REQ-007 SHALL have ports rsp_valid_o out 1 / rsp_ready_i in 1, the response handshake.
REQ-008 SHALL have ports rsp_rdata_o out 32 / rsp_slverr_o out 1 / rsp_timeout_o out 1, the response payload.
REQ-009 SHALL have ports psel_o, penable_o, pwrite_o out 1 / paddr_o out APB_ADDR_WIDTH / pwdata_o out 32, the APB request.
REQ-010 SHALL have ports prdata_i in 32 / pready_i in 1 / pslverr_i in 1, the APB completion.
REQ-011 SHALL have port err_count_o  out  16  count of responses with slverr or timeout.

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP, with at most one outstanding command.
REQ-013 SHALL drive cmd_ready_o=1 only in IDLE; cmd_valid_i&&cmd_ready_o at an edge captures addr/write/wdata and moves to SETUP.
REQ-014 SHALL drive psel_o=1, penable_o=0 in SETUP for exactly one cycle, then move to ACCESS.
REQ-015 SHALL drive psel_o=1, penable_o=1 in ACCESS; paddr_o/pwrite_o/pwdata_o SHALL be constant from SETUP through the last ACCESS cycle.
REQ-016 SHALL, in ACCESS with pready_i=1, move to RESP with rsp_slverr_o=pslverr_i, rsp_timeout_o=0, rsp_rdata_o=prdata_i for reads and 0 for writes.
REQ-017 SHALL count ACCESS cycles with pready_i=0; on the TIMEOUT_CYCLES-th such cycle it moves to RESP with rsp_timeout_o=1, rsp_slverr_o=1, rsp_rdata_o=0.
REQ-018 SHALL hold rsp_valid_o=1 and a stable payload in RESP until rsp_ready_i=1, then move to IDLE.
REQ-019 SHALL drive psel_o=penable_o=0 in IDLE and RESP; paddr_o/pwdata_o hold their last values.
REQ-020 SHALL have zero-wait latency: command accepted at edge N, SETUP cycle N+1, ACCESS cycle N+2, rsp_valid_o high from edge N+3.
REQ-021 SHALL support back-to-back operation: with rsp_ready_i tied 1, the next command is accepted one cycle after RESP (4-cycle throughput).
REQ-022 SHALL increment err_count_o on RESP entry when slverr or timeout occurs, saturating at 16'hFFFF.
REQ-023 SHALL treat pready_i arriving in the same cycle as the timeout limit as a normal completion, not a timeout.

Reset
REQ-024 SHALL, on rst=1, immediately enter IDLE and force psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_slverr_o, rsp_timeout_o, cmd_ready_o to 0, paddr_o, pwdata_o, rsp_rdata_o to 0, and err_count_o to 0.
REQ-025 SHALL abandon any in-flight transfer on reset mid-operation without emitting a response; cmd_ready_o rises on the first edge after rst deasserts.

Structure
REQ-026 SHALL take its FSM state enum and the default TIMEOUT_CYCLES constant from the shared package vmag_apb_pkg.
REQ-027 SHALL be a single module with no sub-modules; the timeout counter and error counter are inline registers.

Verification
REQ-028 Write 0x00 <- 0x2 against a zero-wait slave -> one SETUP and one ACCESS cycle, rsp_valid_o at N+3, slverr=0, rdata=0.
REQ-029 Read 0x08 against a slave with 3 wait states returning 0x00000002 -> ACCESS lasts 4 cycles with stable paddr_o, rsp_rdata_o=0x2.
REQ-030 Read with pready_i stuck 0, TIMEOUT_CYCLES=16 -> 16 ACCESS cycles, rsp_timeout_o=1, rsp_slverr_o=1, err_count_o=1, psel_o low in RESP.
REQ-031 Write to 0xFFC with pslverr_i=1 -> rsp_slverr_o=1, rsp_timeout_o=0, err_count_o increments.
REQ-032 Response backpressure: rsp_ready_i=0 for 5 cycles -> payload stable, cmd_ready_o=0 throughout, then IDLE after acceptance.
REQ-033 Reset asserted in ACCESS -> psel_o/penable_o drop asynchronously, no rsp_valid_o, next command completes normally.
